// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences fetch, decode,
// execute, memory and writeback phases and counts retired instructions.
module mc_control_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_w,
   output logic             pc_w_cond,
   output logic             iord,
   output logic             mem_r,
   output logic             mem_w,
   output logic             ir_w,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_w,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXECUTE   = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EX   = 4'd10,
      ADDI_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t cur;
   state_t nxt;
   logic   retire;

   logic is_r;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_j;
   logic is_addi;

   assign is_r    = (opcode == OP_R);
   assign is_lw   = (opcode == OP_LW);
   assign is_sw   = (opcode == OP_SW);
   assign is_beq  = (opcode == OP_BEQ);
   assign is_j    = (opcode == OP_J);
   assign is_addi = (opcode == OP_ADDI);

   assign state = cur;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cur <= FETCH;
      else
         cur <= nxt;
   end

   // Retired-instruction counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_count <= '0;
      else if (retire)
         instr_count <= instr_count + CNT_W'(1);
   end

   // Next-state and control decode; everything held low in reset.
   always_comb begin
      nxt        = FETCH;
      retire     = 1'b0;
      pc_w       = 1'b0;
      pc_w_cond  = 1'b0;
      iord       = 1'b0;
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      ir_w       = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      reg_w      = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      illegal_op = 1'b0;
      if (rst_n) begin
         case (cur)
            FETCH: begin
               mem_r     = 1'b1;
               alu_src_b = 2'b01;
               ir_w      = mem_ready;
               pc_w      = mem_ready;
               nxt       = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               unique case (1'b1)
                  is_lw,
                  is_sw:   nxt = MEM_ADDR;
                  is_r:    nxt = EXECUTE;
                  is_beq:  nxt = BRANCH;
                  is_j:    nxt = JUMP;
                  is_addi: nxt = ADDI_EX;
                  default: begin
                     nxt        = FETCH;
                     illegal_op = 1'b1;
                  end
               endcase
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               unique case (1'b1)
                  is_lw:   nxt = MEM_READ;
                  is_sw:   nxt = MEM_WRITE;
                  default: nxt = FETCH;
               endcase
            end
            MEM_READ: begin
               mem_r = 1'b1;
               iord  = 1'b1;
               nxt   = mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
               reg_w      = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
            end
            MEM_WRITE: begin
               mem_w  = 1'b1;
               iord   = 1'b1;
               retire = mem_ready;
               nxt    = mem_ready ? FETCH : MEM_WRITE;
            end
            EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               nxt       = R_WB;
            end
            R_WB: begin
               reg_w   = 1'b1;
               reg_dst = 1'b1;
               retire  = 1'b1;
            end
            BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b01;
               pc_w_cond = 1'b1;
               pc_src    = 2'b01;
               retire    = 1'b1;
            end
            JUMP: begin
               pc_w   = 1'b1;
               pc_src = 2'b10;
               retire = 1'b1;
            end
            ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               nxt       = ADDI_WB;
            end
            ADDI_WB: begin
               reg_w  = 1'b1;
               retire = 1'b1;
            end
            default: nxt = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instruction-level reference model
// checked every cycle, plus literal state traces and counts.
module tb_mc_control_fsm;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_w;
   logic        pc_w_cond;
   logic        iord;
   logic        mem_r;
   logic        mem_w;
   logic        ir_w;
   logic        mem_to_reg;
   logic        reg_dst;
   logic        reg_w;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  pc_src;
   logic [3:0]  state;
   logic        illegal_op;
   logic [31:0] instr_count;

   mc_control_fsm #(.CNT_W(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .opcode(opcode),
      .mem_ready(mem_ready),
      .pc_w(pc_w),
      .pc_w_cond(pc_w_cond),
      .iord(iord),
      .mem_r(mem_r),
      .mem_w(mem_w),
      .ir_w(ir_w),
      .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst),
      .reg_w(reg_w),
      .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b),
      .alu_op(alu_op),
      .pc_src(pc_src),
      .state(state),
      .illegal_op(illegal_op),
      .instr_count(instr_count)
   );

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   int n_cmp = 0;
   int n_bad = 0;

   int trace[$];
   int mw_seen;
   int ir_seen;
   int pcw_seen;
   int ill_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [63:0] got,
                      input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  name, got, want, $time);
      end
   endtask

   // Reference model: phase list per instruction, chosen at decode.
   int          m_state;
   int          m_route[$];
   logic [31:0] m_cnt;

   function automatic logic supported(input logic [5:0] op);
      return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0;
         m_cnt   = '0;
         m_route.delete();
      end else if (m_state == 0) begin
         if (mem_ready) m_state = 1;
      end else if (m_state == 1) begin
         m_route.delete();
         case (opcode)
            OP_LW:   m_route = '{2, 3, 4};
            OP_SW:   m_route = '{2, 5};
            OP_R:    m_route = '{6, 7};
            OP_BEQ:  m_route = '{8};
            OP_J:    m_route = '{9};
            OP_ADDI: m_route = '{10, 11};
            default: m_route.delete();
         endcase
         if (m_route.size() == 0) m_state = 0;
         else m_state = m_route.pop_front();
      end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
         m_state = m_state;
      end else if (m_route.size() > 0) begin
         m_state = m_route.pop_front();
      end else begin
         m_state = 0;
         m_cnt   = m_cnt + 32'd1;
      end
   end

   // Control word the specification lists for a phase.
   function automatic logic [16:0] exp_ctrl(input int st,
                                            input logic mr,
                                            input logic [5:0] op);
      logic pw, pwc, io, rd, wr, irw, m2r, rdst, rw, asa, ill;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, io, rd, wr, irw, m2r, rdst, rw, asa, ill} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         0:  begin rd = 1; asb = 2'b01; irw = mr; pw = mr; end
         1:  begin asb = 2'b11; ill = !supported(op); end
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin rd = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin wr = 1; io = 1; end
         6:  begin asa = 1; aop = 2'b10; end
         7:  begin rw = 1; rdst = 1; end
         8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         9:  begin pw = 1; psrc = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: begin rw = 1; end
         default: ;
      endcase
      return {pw, pwc, io, rd, wr, irw, m2r, rdst, rw, asa,
              asb, aop, psrc, ill};
   endfunction

   logic [16:0] dut_ctrl;
   assign dut_ctrl = {pc_w, pc_w_cond, iord, mem_r, mem_w, ir_w,
                      mem_to_reg, reg_dst, reg_w, alu_src_a,
                      alu_src_b, alu_op, pc_src, illegal_op};

   // Every-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("ctrl_rst", 64'(dut_ctrl), 64'd0);
         chk("state_rst", 64'(state), 64'd0);
         chk("count_rst", 64'(instr_count), 64'd0);
      end else begin
         chk("ctrl", 64'(dut_ctrl),
             64'(exp_ctrl(m_state, mem_ready, opcode)));
         chk("state", 64'(state), 64'(m_state));
         chk("count", 64'(instr_count), 64'(m_cnt));
      end
   end

   task automatic cyc(input logic [5:0] op, input logic mr);
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = mr;
      @(negedge clk);
      #1;
      trace.push_back(int'(state));
      mw_seen  += int'(mem_w);
      ir_seen  += int'(ir_w);
      pcw_seen += int'(pc_w);
      ill_seen += int'(illegal_op);
   endtask

   task automatic run(input logic [5:0] op,
                      input logic [31:0] mr_bits,
                      input int n);
      for (int i = 0; i < n; i++)
         cyc(op, mr_bits[n-1-i]);
   endtask

   task automatic clr_seen();
      trace.delete();
      mw_seen  = 0;
      ir_seen  = 0;
      pcw_seen = 0;
      ill_seen = 0;
   endtask

   // seq holds one state per nibble, first state most significant.
   task automatic chk_trace(input string name,
                            input logic [63:0] seq,
                            input int len);
      logic [63:0] got;
      got = '0;
      foreach (trace[i]) got = (got << 4) | 64'(trace[i] & 15);
      chk({name, "_len"}, 64'(trace.size()), 64'(len));
      chk(name, got, seq);
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = OP_R;
      mem_ready = 1'b0;
      clr_seen();
      #1;
      chk("init_state", 64'(state), 64'd0);
      chk("init_mem_r", 64'(mem_r), 64'd0);
      chk("init_ctrl", 64'(dut_ctrl), 64'd0);
      chk("init_count", 64'(instr_count), 64'd0);
      #11;
      rst_n = 1'b1;

      clr_seen();
      run(OP_R, 32'b11110, 5);
      chk_trace("r_trace", 64'h01670, 5);
      chk("r_ir_w", 64'(ir_seen), 64'd1);
      chk("r_count", 64'(instr_count), 64'd1);

      clr_seen();
      run(OP_LW, 32'b11100110, 8);
      chk_trace("lw_trace", 64'h01233340, 8);
      chk("lw_count", 64'(instr_count), 64'd2);

      clr_seen();
      run(OP_SW, 32'b1111, 4);
      chk_trace("sw_trace", 64'h0125, 4);
      chk("sw_mem_w", 64'(mw_seen), 64'd1);
      clr_seen();
      run(OP_BEQ, 32'b1110, 4);
      chk_trace("beq_trace", 64'h0180, 4);
      chk("sw_beq_count", 64'(instr_count), 64'd4);

      clr_seen();
      run(OP_J, 32'b1110, 4);
      chk_trace("j_trace", 64'h0190, 4);
      chk("j_count", 64'(instr_count), 64'd5);

      clr_seen();
      run(OP_ADDI, 32'b11110, 5);
      chk_trace("addi_trace", 64'h01AB0, 5);
      chk("addi_count", 64'(instr_count), 64'd6);

      clr_seen();
      run(OP_BAD, 32'b110, 3);
      chk_trace("ill_trace", 64'h010, 3);
      chk("ill_pulses", 64'(ill_seen), 64'd1);
      chk("ill_count", 64'(instr_count), 64'd6);

      clr_seen();
      run(OP_R, 32'b00011110, 8);
      chk_trace("stall_trace", 64'h00001670, 8);
      chk("stall_ir_w", 64'(ir_seen), 64'd1);
      chk("stall_pc_w", 64'(pcw_seen), 64'd1);
      chk("stall_count", 64'(instr_count), 64'd7);

      clr_seen();
      run(OP_R, 32'b110, 3);
      chk_trace("pre_rst_trace", 64'h016, 3);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_state", 64'(state), 64'd0);
      chk("arst_ctrl", 64'(dut_ctrl), 64'd0);
      chk("arst_count", 64'(instr_count), 64'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      cyc(OP_R, 1'b0);
      chk("post_rst_mem_r", 64'(mem_r), 64'd1);
      chk("post_rst_alu_b", 64'(alu_src_b), 64'd1);
      chk("post_rst_state", 64'(state), 64'd0);
      cyc(OP_R, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multi-cycle MIPS datapath.
- Sequences the instruction register (ir_w), the PC, memory, the register file and the ALU through the fetch, decode, execute, memory and writeback phases.
- Reads the opcode field decoded by the instruction register and drives all datapath enables and mux selects.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
opcode  input  6  instruction opcode from the instruction register; valid from DECODE onward.
mem_ready  input  1  memory has completed the current read or write this cycle.
pc_w  output  1  unconditional PC write.
pc_w_cond  output  1  PC write qualified by ALU zero (beq).
iord  output  1  memory address select: 0 = PC, 1 = ALU out.
mem_r  output  1  memory read request.
mem_w  output  1  memory write request.
ir_w  output  1  instruction register load.
mem_to_reg  output  1  register write-data select: 1 = memory data, 0 = ALU out.
reg_dst  output  1  register write-address select: 1 = rd, 0 = rt.
reg_w  output  1  register file write.
alu_src_a  output  1  ALU A select: 0 = PC, 1 = rs.
alu_src_b  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
alu_op  output  2  ALU control class: 00 = add, 01 = sub, 10 = use funct.
pc_src  output  2  PC source: 00 = ALU, 01 = ALU out register, 10 = jump address.
state  output  4  current state encoding (debug).
illegal_op  output  1  pulses in DECODE when the opcode is unsupported.
instr_count  output  CNT_W  retired-instruction counter.

Behaviour:
- Reset (rst_n=0, async):
  - state=FETCH(0); instr_count=0.
  - All control outputs are forced to 0 while rst_n=0.
  - Reset mid-instruction aborts the instruction; nothing is retired.
- Default: every control output not listed for a state is 0.
- Outputs are decoded from state, except that ir_w/pc_w in FETCH and the exit of the wait states are gated by mem_ready, and illegal_op is gated by opcode.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States, outputs and next state:
  - FETCH(0): mem_r=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_w=pc_w=mem_ready. Stay while !mem_ready, else DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - lw/sw -> MEM_ADDR
    - R -> EXECUTE
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDI_EX
    - other -> FETCH, with illegal_op=1 for this cycle.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEM_READ; sw -> MEM_WRITE.
  - MEM_READ(3): mem_r=1, iord=1. Stay while !mem_ready, else MEM_WB.
  - MEM_WB(4): reg_w=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WRITE(5): mem_w=1, iord=1. Stay while !mem_ready, else FETCH.
  - EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
  - R_WB(7): reg_w=1, reg_dst=1, mem_to_reg=0 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_w_cond=1, pc_src=01 -> FETCH.
  - JUMP(9): pc_w=1, pc_src=10 -> FETCH.
  - ADDI_EX(10): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
  - ADDI_WB(11): reg_w=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - Encodings 12-15: unreachable; treat as FETCH on the next edge, all controls 0.
- Latency with mem_ready held at 1: beq/j 3 cycles; R/sw/addi 4 cycles; lw 5 cycles. Each stall cycle adds 1.
- Opcode is sampled only in DECODE and MEM_ADDR; it is don't-care elsewhere.
- instr_count:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE (with mem_ready), R_WB, BRANCH, JUMP or ADDI_WB.
  - Never increments on the illegal-opcode exit from DECODE.
  - Wraps modulo 2^CNT_W.
- mem_r and mem_w are never asserted in the same cycle.

Test Plan:
- Reset: rst_n=0 mid-EXECUTE -> state=0 and all controls 0 immediately (async). After release, cycle 1 shows mem_r=1, alu_src_b=01.
- R-type, opcode=000000, mem_ready=1 -> states 0,1,6,7,0. ir_w=1 in cycle 1; reg_w=1 with reg_dst=1 in cycle 4; instr_count 0 -> 1.
- lw, opcode=100011, mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. mem_r=1 and iord=1 throughout state 3; mem_to_reg=1 in state 4.
- sw then beq, mem_ready=1 -> sw visits 0,1,2,5 with mem_w=1 once; beq visits 0,1,8 with pc_w_cond=1, alu_op=01; instr_count +2.
- j, opcode=000010 -> pc_w=1, pc_src=10 in state 9.
- addi, opcode=001000 -> states 10,11 with reg_w=1, reg_dst=0.
- Illegal opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; instr_count unchanged.
- Fetch stall: mem_ready=0 for 3 cycles in FETCH -> ir_w=0 and pc_w=0 during the stall; ir_w=pc_w=1 only in the ready cycle.
